mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port (MEM_ADDRESS / MEM_DATAOUT / MEM_DATAIN / mem_rw / mem_val / mem_ready) between two cache controllers, e.g. I-cache on port 0 and D-cache on port 1.
- Each port can present a one-cycle request. The arbiter latches it into a per-port pending slot and grants memory round-robin.
- It runs the memory val/ready sequence and returns read data plus completion to the owning requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- TIMEOUT_CYC, 255, watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- REQ0_ADDRESS  in  ADDR_W  port 0 address.
- REQ0_DATAIN  in  DATA_W  port 0 write data.
- REQ0_DATAOUT  out  DATA_W  port 0 read data.
- req0_rw  in  1  port 0 direction: 1=write, 0=read.
- req0_val  in  1  port 0 request strobe.
- req0_ready  out  1  port 0 slot free.
- req0_done  out  1  port 0 completion pulse.
- req0_err  out  1  port 0 timeout pulse.
- REQ1_* / req1_*  same widths and meanings for port 1.
- MEM_ADDRESS  out  ADDR_W  memory address.
- MEM_DATAOUT  out  DATA_W  write data to memory.
- MEM_DATAIN  in  DATA_W  read data from memory.
- mem_rw  out  1  memory direction: 1=write.
- mem_val  out  1  memory request.
- mem_ready  in  1  memory ready/busy.
- grant  out  1  current or last owner port.

Behaviour:
- Reset (rst=0, async):
  - Outputs: all DATAOUT=0, mem_val=0, mem_rw=0, MEM_ADDRESS=0, MEM_DATAOUT=0, done=0, err=0, req0_ready=req1_ready=1, grant=1.
  - State: FSM=IDLE, pending slots cleared, last_grant=1 so port 0 wins first.
  - Reset mid-transaction aborts it silently; no done pulse.
- Capture:
  - When reqN_val=1 and reqN_ready=1 at a rising edge, latch address, rw and data into slot N.
  - pendN<=1. reqN_ready falls the next cycle and stays 0 until completion.
  - reqN_val while reqN_ready=0 is ignored.
- FSM states IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE:
  - IDLE:
    - Only pend0 set: grant port 0. Only pend1 set: grant port 1.
    - Both set: grant !last_grant.
    - Grant loads MEM_ADDRESS, MEM_DATAOUT and mem_rw from the slot, then goes to ISSUE.
    - A request captured at an edge can be granted at the following edge.
  - ISSUE: mem_val=1. Advance to WAIT_LO at the first edge where mem_ready=1. mem_val=0 from WAIT_LO on.
  - WAIT_LO: wait for mem_ready=0, then go to WAIT_HI.
  - WAIT_HI: wait for mem_ready=1.
    - On that edge, for a read, REQn_DATAOUT<=MEM_DATAIN; for a write, DATAOUT is unchanged.
    - Then go to DONE.
  - DONE (1 cycle): reqN_done=1, reqN_ready=1, pendN cleared, last_grant<=N, then IDLE.
- Ordering and hold rules:
  - Non-owner port may capture a request in any state; it is served next.
  - A new request on the owner port is accepted in its DONE cycle.
  - REQn_DATAOUT holds until the next read completion on that port.
  - MEM_ADDRESS, MEM_DATAOUT and mem_rw stay stable from ISSUE through WAIT_HI.
- Latency: capture -> mem_val asserted = 2 edges, with memory idle and no contention.
- grant = owner while not IDLE, last owner while IDLE.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_LO and counts in WAIT_LO and WAIT_HI.
  - On reaching TIMEOUT_CYC, go to DONE with reqN_err=1 in the same cycle as reqN_done=1.
  - REQn_DATAOUT<=0 on a timed-out read. Round-robin still updates.
- Undefined: no counter; the arbiter waits indefinitely. req0_err and req1_err are tied to 0, and the ports always exist.

Test Plan:
- Single write: req0 write, addr 0x0B00, data 0x122. Memory drops ready 1 cycle after mem_val, raises it 2 cycles later.
  - Expect mem_val high 1 cycle, MEM_ADDRESS=0x0B00, MEM_DATAOUT=0x122, mem_rw=1.
  - Then req0_done pulse, req0_ready=1, REQ0_DATAOUT=0.
- Single read: req1 read, addr 0xBB00; memory returns 0x344 when ready rises.
  - Expect REQ1_DATAOUT=0x344, req1_done 1 cycle, grant=1.
- Simultaneous: req0 read 0xAB00 and req1 read 0xEB00 on the same edge, from reset.
  - Expect port 0 served first, then port 1, each with its own data (0x11, 0x66).
  - Next simultaneous pair: port 1 served first.
- Back-to-back: re-request on port 0 in its DONE cycle while port 1 is pending.
  - Expect port 1 granted before port 0's second request.
- Reset mid-operation: assert rst in WAIT_HI.
  - Expect mem_val=0, all ready=1, no done pulse; a fresh request afterwards completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8: memory holds ready low forever.
  - Expect req0_done=req0_err=1 exactly 8 cycles after WAIT_LO entry, REQ0_DATAOUT=0.
  - Next request is served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side signals of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] REQ0_ADDRESS, REQ1_ADDRESS, MEM_ADDRESS;
  logic [DATA_W-1:0] REQ0_DATAIN, REQ1_DATAIN, REQ0_DATAOUT, REQ1_DATAOUT;
  logic [DATA_W-1:0] MEM_DATAOUT, MEM_DATAIN;
  logic req0_rw, req0_val, req0_ready, req0_done, req0_err;
  logic req1_rw, req1_val, req1_ready, req1_done, req1_err;
  logic mem_rw, mem_val, mem_ready, grant;
  modport slave (
    input REQ0_ADDRESS, REQ0_DATAIN, req0_rw, req0_val,
    input REQ1_ADDRESS, REQ1_DATAIN, req1_rw, req1_val,
    input MEM_DATAIN, mem_ready,
    output REQ0_DATAOUT, req0_ready, req0_done, req0_err,
    output REQ1_DATAOUT, req1_ready, req1_done, req1_err,
    output MEM_ADDRESS, MEM_DATAOUT, mem_rw, mem_val, grant
  );
  modport master (
    output REQ0_ADDRESS, REQ0_DATAIN, req0_rw, req0_val,
    output REQ1_ADDRESS, REQ1_DATAIN, req1_rw, req1_val,
    output MEM_DATAIN, mem_ready,
    input REQ0_DATAOUT, req0_ready, req0_done, req0_err,
    input REQ1_DATAOUT, req1_ready, req1_done, req1_err,
    input MEM_ADDRESS, MEM_DATAOUT, mem_rw, mem_val, grant
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one val/ready memory port between two requesters.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts stalled transfers with a reqN_err pulse.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clock,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] in_addr [2];
  logic [ADDR_W-1:0] s_addr [2];
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] in_data [2];
  logic [DATA_W-1:0] s_data [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0] val, in_rw, s_rw, pend, ready, done, cap, err;
  logic owner, pick, mem_wr, fin, abort, timed_out;
  if (TIMEOUT_CYC < 1) begin : g_chk
    $error("TIMEOUT_CYC must be at least 1");
  end
  assign in_addr[0] = bus.REQ0_ADDRESS;
  assign in_addr[1] = bus.REQ1_ADDRESS;
  assign in_data[0] = bus.REQ0_DATAIN;
  assign in_data[1] = bus.REQ1_DATAIN;
  assign val = {bus.req1_val, bus.req0_val};
  assign in_rw = {bus.req1_rw, bus.req0_rw};
  // the owner's slot reads as free during DONE so it can re-request back to back
  assign done = (state == DONE) ? {owner, ~owner} : 2'b00;
  assign ready = ~pend | done;
  assign cap = val & ready;
  assign pick = &pend ? ~owner : pend[1];
  assign fin = state == WAIT_HI && bus.mem_ready;
  assign abort = timed_out && !fin && (state == WAIT_LO || state == WAIT_HI);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic to_flag;
  assign timed_out = cnt == CW'(TIMEOUT_CYC - 1);
  assign err = {2{to_flag}} & done;
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      cnt <= '0;
      to_flag <= 1'b0;
    end else begin
      cnt <= (state == WAIT_LO || state == WAIT_HI) ? cnt + 1'b1 : '0;
      to_flag <= abort;
    end
`else
  assign timed_out = 1'b0;
  assign err = 2'b00;
`endif
  always_ff @(posedge clock or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = |pend ? ISSUE : IDLE;
      ISSUE: state_nx = bus.mem_ready ? WAIT_LO : ISSUE;
      WAIT_LO: state_nx = abort ? DONE : bus.mem_ready ? WAIT_LO : WAIT_HI;
      WAIT_HI: state_nx = (fin || abort) ? DONE : WAIT_HI;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      s_addr <= '{default: '0};
      s_data <= '{default: '0};
      rd_data <= '{default: '0};
      s_rw <= '0;
      pend <= '0;
      owner <= 1'b1;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wr <= 1'b0;
    end else begin
      pend <= cap | (pend & ~done);
      for (int i = 0; i < 2; i++)
        if (cap[i]) begin
          s_addr[i] <= in_addr[i];
          s_data[i] <= in_data[i];
          s_rw[i] <= in_rw[i];
        end
      if (state == IDLE && |pend) begin
        owner <= pick;
        mem_addr <= s_addr[pick];
        mem_wdata <= s_data[pick];
        mem_wr <= s_rw[pick];
      end
      if ((fin || abort) && !mem_wr) rd_data[owner] <= abort ? '0 : bus.MEM_DATAIN;
    end
  assign bus.REQ0_DATAOUT = rd_data[0];
  assign bus.REQ1_DATAOUT = rd_data[1];
  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign bus.req0_done = done[0];
  assign bus.req1_done = done[1];
  assign bus.req0_err = err[0];
  assign bus.req1_err = err[1];
  assign bus.MEM_ADDRESS = mem_addr;
  assign bus.MEM_DATAOUT = mem_wdata;
  assign bus.mem_rw = mem_wr;
  assign bus.mem_val = state == ISSUE;
  assign bus.grant = owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench checked every cycle against a transaction-level model
// of the arbiter and a scripted memory; define ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 64;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 0;
`endif
  logic clock = 1'b0, rst = 1'b0;
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO > 0 ? TO : 255)) dut (
    .clock(clock), .rst(rst), .bus(bus));
  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  bit m_out [2], m_rw [2], e_done [2], e_err [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd [2], m_dout [2];
  int phase, k, b, lo, f_b = -1, f_lo = -1;
  bit own, last, hang, f_hang = 0, t_rw;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd, rdata;
  logic [DW-1:0] img [logic [AW-1:0]];

  task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    phase = 0; last = 1; own = 1; hang = 0;
    for (int n = 0; n < 2; n++) begin
      m_out[n] = 0; m_dout[n] = '0; e_done[n] = 0; e_err[n] = 0;
    end
  endtask

  task automatic drive(int n, bit rw, logic [AW-1:0] a, logic [DW-1:0] d);
    if (n == 0) begin
      bus.req0_val = 1; bus.req0_rw = rw; bus.REQ0_ADDRESS = a; bus.REQ0_DATAIN = d;
    end else begin
      bus.req1_val = 1; bus.req1_rw = rw; bus.REQ1_ADDRESS = a; bus.REQ1_DATAIN = d;
    end
  endtask

  task automatic chk_reset();
    chk("rst_mem_val", bus.mem_val, 0);
    chk("rst_mem_rw", bus.mem_rw, 0);
    chk("rst_mem_addr", bus.MEM_ADDRESS, 0);
    chk("rst_mem_wdata", bus.MEM_DATAOUT, 0);
    chk("rst_dout0", bus.REQ0_DATAOUT, 0);
    chk("rst_dout1", bus.REQ1_DATAOUT, 0);
    chk("rst_done0", bus.req0_done, 0);
    chk("rst_done1", bus.req1_done, 0);
    chk("rst_err0", bus.req0_err, 0);
    chk("rst_err1", bus.req1_err, 0);
    chk("rst_ready0", bus.req0_ready, 1);
    chk("rst_ready1", bus.req1_ready, 1);
    chk("rst_grant", bus.grant, 1);
  endtask

  task automatic observe();
    chk("mem_val", bus.mem_val, phase == 1 && k <= b);
    chk("grant", bus.grant, phase == 0 ? last : own);
    if (phase == 1) begin
      chk("mem_addr", bus.MEM_ADDRESS, t_addr);
      chk("mem_rw", bus.mem_rw, t_rw);
      if (t_rw) chk("mem_wdata", bus.MEM_DATAOUT, t_wd);
    end
    chk("done0", bus.req0_done, e_done[0]);
    chk("done1", bus.req1_done, e_done[1]);
    chk("err0", bus.req0_err, e_err[0]);
    chk("err1", bus.req1_err, e_err[1]);
    chk("ready0", bus.req0_ready, !m_out[0] || (phase == 2 && !own));
    chk("ready1", bus.req1_ready, !m_out[1] || (phase == 2 && own));
    chk("dout0", bus.REQ0_DATAOUT, m_dout[0]);
    chk("dout1", bus.REQ1_DATAOUT, m_dout[1]);
  endtask

  // memory script per transaction: b busy cycles, one ready cycle, lo low cycles, ready with data
  task automatic step();
    bit v [2], cap [2], fin, abort;
    v[0] = bus.req0_val; v[1] = bus.req1_val;
    bus.mem_ready = phase != 1 || k == b || (!hang && k == b + 1 + lo);
    bus.MEM_DATAIN = (phase == 1 && !hang && k == b + 1 + lo) ? rdata : {$urandom, $urandom};
    for (int n = 0; n < 2; n++) begin
      cap[n] = v[n] && (!m_out[n] || (phase == 2 && own == (n == 1)));
      e_done[n] = 0; e_err[n] = 0;
    end
    case (phase)
      0: if (m_out[0] || m_out[1]) begin
        own = (m_out[0] && m_out[1]) ? !last : m_out[1];
        t_addr = m_addr[own]; t_rw = m_rw[own]; t_wd = m_wd[own];
        b = f_b >= 0 ? f_b : int'($urandom_range(2));
        lo = f_lo >= 0 ? f_lo : 1 + int'($urandom_range(2));
        hang = f_hang;
        rdata = img.exists(t_addr) ? img[t_addr] : {$urandom, $urandom};
        phase = 1; k = 0;
      end
      1: begin
        fin = !hang && k == b + 1 + lo;
        abort = TO > 0 && !fin && k > b && k - b == TO;
        if (fin || abort) begin
          phase = 2; e_done[own] = 1; e_err[own] = abort;
          if (!t_rw) m_dout[own] = abort ? '0 : rdata;
        end
        k++;
      end
      default: begin
        phase = 0; m_out[own] = 0; last = own;
      end
    endcase
    if (cap[0]) begin
      m_out[0] = 1; m_rw[0] = bus.req0_rw; m_addr[0] = bus.REQ0_ADDRESS; m_wd[0] = bus.REQ0_DATAIN;
    end
    if (cap[1]) begin
      m_out[1] = 1; m_rw[1] = bus.req1_rw; m_addr[1] = bus.REQ1_ADDRESS; m_wd[1] = bus.REQ1_DATAIN;
    end
    @(posedge clock);
    @(negedge clock);
    bus.req0_val = 0; bus.req1_val = 0;
    observe();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hard_reset();
    rst = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk_reset();
    rst = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    bus.req0_val = 0; bus.req1_val = 0; bus.req0_rw = 0; bus.req1_rw = 0;
    bus.REQ0_ADDRESS = '0; bus.REQ1_ADDRESS = '0; bus.REQ0_DATAIN = '0; bus.REQ1_DATAIN = '0;
    bus.mem_ready = 1; bus.MEM_DATAIN = '0;
    model_reset();
    img[32'h0000BB00] = 64'h344;
    img[32'h0000AB00] = 64'h11;
    img[32'h0000EB00] = 64'h66;
    repeat (3) @(negedge clock);
    chk_reset();
    rst = 1;
    f_b = 0; f_lo = 2;
    drive(0, 1, 32'h0B00, 64'h122); step(); run(10);
    chk("wr_dout0", bus.REQ0_DATAOUT, 64'h0);
    drive(1, 0, 32'hBB00, '0); step(); run(10);
    chk("rd_dout1", bus.REQ1_DATAOUT, 64'h344);
    f_b = -1; f_lo = -1;
    hard_reset();
    drive(0, 0, 32'hAB00, '0); drive(1, 0, 32'hEB00, '0); step(); run(25);
    chk("sim_dout0", bus.REQ0_DATAOUT, 64'h11);
    chk("sim_dout1", bus.REQ1_DATAOUT, 64'h66);
    drive(0, 0, 32'hAB08, '0); drive(1, 0, 32'hEB08, '0); step(); run(25);
    drive(0, 1, 32'h1000, 64'hA5); step();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin step(); hit = phase == 1; end
    drive(1, 0, 32'h2000, '0); step();
    hit = phase == 2 && !own;
    for (int i = 0; i < 20 && !hit; i++) begin step(); hit = phase == 2 && !own; end
    chk("b2b_done_seen", hit, 1);
    drive(0, 0, 32'h3000, '0); step(); run(30);
    f_b = 0; f_lo = 3;
    drive(0, 0, 32'h4000, '0); step();
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin step(); hit = phase == 1 && k >= b + 2; end
    chk("reach_wait_hi", hit, 1);
    #1 rst = 0;
    #1 chk_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset();
    model_reset();
    rst = 1;
    f_b = -1; f_lo = -1;
    drive(1, 0, 32'hBB00, '0); step(); run(12);
    chk("post_rst_dout1", bus.REQ1_DATAOUT, 64'h344);
`ifdef ARB_TIMEOUT_EN
    f_b = 0; f_hang = 1;
    drive(0, 0, 32'h0C00, '0); step();
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin step(); hit = e_done[0]; end
    chk("timeout_seen", hit, 1);
    chk("timeout_err0", bus.req0_err, 1);
    f_hang = 0; f_b = -1;
    drive(0, 0, 32'hAB00, '0); step(); run(12);
    chk("after_to_dout0", bus.REQ0_DATAOUT, 64'h11);
`endif
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 2; n++)
        if ($urandom_range(3) == 0) drive(n, 1'($urandom_range(1)), $urandom, {$urandom, $urandom});
      step();
    end
    run(30);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
